// File: rtl/tetris_pkg.sv
// tetris_pkg: shared definitions for the playfield merger.
//   - DEF_COLS / DEF_ROWS : default board geometry
//   - OP_CHECK / OP_LOCK  : command opcodes carried on cmd_op
//   - state_t             : merger FSM state encoding
//   - mask_bit_idx()      : bit position of cell (r,c) inside a 16-bit piece mask
package tetris_pkg;

  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;

  localparam logic OP_CHECK = 1'b0;
  localparam logic OP_LOCK  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Cell (r,c) of the 4x4 mask lives at bit 15-(4r+c); {r,c} is exactly 4r+c.
  function automatic logic [3:0] mask_bit_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'd15 - {r, c};
  endfunction

endpackage

// File: rtl/piece_board_merger_if.sv
// piece_board_merger_if: command/response bundle between the piece source and
// the board merger.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : OP_CHECK or OP_LOCK
//   cmd_mask            : 4x4 piece configuration
//   pos_x / pos_y       : board cell of mask cell (0,0)
//   rsp_valid           : one-cycle response strobe
//   rsp_collision       : collision result (held until the next response)
//   rsp_lines           : number of rows cleared (held until the next response)
// Modports: master = command issuer, slave = board merger.
interface piece_board_merger_if #(
  parameter int ROW_AW = 5
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [15:0]       cmd_mask;
  logic [4:0]        pos_x;
  logic [ROW_AW-1:0] pos_y;
  logic              rsp_valid;
  logic              rsp_collision;
  logic [2:0]        rsp_lines;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, pos_x, pos_y,
    input  cmd_ready, rsp_valid, rsp_collision, rsp_lines
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, pos_x, pos_y,
    output cmd_ready, rsp_valid, rsp_collision, rsp_lines
  );

endinterface

// File: rtl/board_row_full.sv
// board_row_full: combinational test that every cell of one board row is set.
//   row  : COLS-wide board row (bit c = column c)
//   full : 1 when all COLS bits are 1
module board_row_full #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] row,
  output logic            full
);

  assign full = &row;

endmodule

// File: rtl/piece_board_merger.sv
// piece_board_merger: owns the playfield occupancy array. Each command either
// checks a 4x4 piece at a position for collision, or (LOCK) checks it, ORs it
// into the board and, when LINE_CLEAR_EN is defined, removes full rows.
//   clk, resetn : clock, asynchronous active-low reset
//   board_clr   : zero the whole board (acted on only in IDLE, blocks commands)
//   bus         : piece_board_merger_if.slave command/response bundle
//   rd_row      : render read address
//   rd_data     : board[rd_row], combinational, zero for rd_row >= ROWS
// Build option: LINE_CLEAR_EN enables the CLEAR scan after a LOCK; without it
// WRITE goes straight to RESP, rsp_lines is 0 and full rows stay on the board.
module piece_board_merger
  import tetris_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ROW_AW = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 board_clr,
  piece_board_merger_if.slave  bus,
  input  logic [ROW_AW-1:0]    rd_row,
  output logic [COLS-1:0]      rd_data
);

  localparam logic [5:0] COLS6 = 6'(COLS);
  localparam logic [5:0] ROWS6 = 6'(ROWS);

  state_t            state_reg, state_next;
  logic              op_reg;
  logic [15:0]       mask_reg;
  logic [4:0]        pos_x_reg;
  logic [ROW_AW-1:0] pos_y_reg;
  logic [1:0]        r_cnt_reg;
  logic              coll_reg;
  logic              rsp_coll_reg;

  logic [COLS-1:0]   board_reg [ROWS];
  logic [COLS-1:0]   row_next  [ROWS];

  logic              accept;
  logic              clr_all;
  logic [5:0]        tgt_row;
  logic              tgt_in_range;
  logic [COLS-1:0]   tgt_cur;
  logic [COLS-1:0]   wr_bits;
  logic [5:0]        col;
  logic              hit;

  assign bus.cmd_ready     = resetn && (state_reg == ST_IDLE) && !board_clr;
  assign accept            = (state_reg == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign clr_all           = (state_reg == ST_IDLE) && board_clr;
  assign bus.rsp_valid     = (state_reg == ST_RESP);
  assign bus.rsp_collision = rsp_coll_reg;

  assign rd_data = (6'(rd_row) < ROWS6) ? board_reg[rd_row] : '0;

  // Board row addressed by the current mask row; 6-bit sum so nothing wraps.
  assign tgt_row      = 6'(pos_y_reg) + {4'd0, r_cnt_reg};
  assign tgt_in_range = (tgt_row < ROWS6);
  assign tgt_cur      = tgt_in_range ? board_reg[tgt_row[ROW_AW-1:0]] : '0;

  // Per mask row: collision test and the bits to OR in during WRITE. Only
  // in-range cells ever reach wr_bits.
  always_comb begin
    hit     = 1'b0;
    wr_bits = '0;
    col     = '0;
    for (int c = 0; c < 4; c++) begin
      col = 6'(pos_x_reg) + 6'(c);
      if (mask_reg[mask_bit_idx(r_cnt_reg, 2'(c))]) begin
        if (!tgt_in_range || (col >= COLS6)) begin
          hit = 1'b1;
        end else begin
          if ((tgt_cur & (COLS'(1) << col)) != '0) begin
            hit = 1'b1;
          end
          wr_bits = wr_bits | (COLS'(1) << col);
        end
      end
    end
  end

`ifdef LINE_CLEAR_EN
  logic [ROW_AW-1:0] ptr_reg;
  logic [2:0]        lines_reg;
  logic [2:0]        rsp_lines_reg;
  logic [COLS-1:0]   scan_row;
  logic              row_full;
  logic              shift_en;
  logic [COLS-1:0]   above_row [ROWS];

  assign scan_row      = board_reg[ptr_reg];
  assign shift_en      = (state_reg == ST_CLEAR) && row_full;
  assign bus.rsp_lines = rsp_lines_reg;

  board_row_full #(.COLS(COLS)) u_row_full (
    .row  (scan_row),
    .full (row_full)
  );
`else
  assign bus.rsp_lines = 3'd0;
`endif

  // Next value of every board row. A full row at the scan pointer collapses
  // rows 0..ptr down by one in a single cycle; row 0 refills with zeros.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic wr_hit;
    assign wr_hit = (state_reg == ST_WRITE) && tgt_in_range && (tgt_row == 6'(gi));
`ifdef LINE_CLEAR_EN
    logic shift_hit;
    assign shift_hit = shift_en && (ptr_reg >= ROW_AW'(gi));
    if (gi == 0) begin : g_top
      assign above_row[gi] = '0;
    end else begin : g_below
      assign above_row[gi] = board_reg[gi-1];
    end
`endif
    assign row_next[gi] = clr_all   ? '0 :
                          wr_hit    ? (board_reg[gi] | wr_bits) :
`ifdef LINE_CLEAR_EN
                          shift_hit ? above_row[gi] :
`endif
                          board_reg[gi];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROWS; i++) board_reg[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) board_reg[i] <= row_next[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        // The last row's hit has not been folded into coll_reg yet.
        if (r_cnt_reg == 2'd3) begin
          if ((op_reg == OP_CHECK) || coll_reg || hit) state_next = ST_RESP;
          else                                         state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_cnt_reg == 2'd3) begin
`ifdef LINE_CLEAR_EN
          state_next = ST_CLEAR;
`else
          state_next = ST_RESP;
`endif
        end
      end
      ST_CLEAR: begin
`ifdef LINE_CLEAR_EN
        if (!row_full && (ptr_reg == '0)) state_next = ST_RESP;
`else
        state_next = ST_IDLE;
`endif
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Command capture, row counter and sticky collision flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_reg       <= OP_CHECK;
      mask_reg     <= '0;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      r_cnt_reg    <= '0;
      coll_reg     <= 1'b0;
      rsp_coll_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= bus.cmd_op;
        mask_reg  <= bus.cmd_mask;
        pos_x_reg <= bus.pos_x;
        pos_y_reg <= bus.pos_y;
        r_cnt_reg <= '0;
        coll_reg  <= 1'b0;
      end else if (state_reg == ST_CHECK) begin
        coll_reg  <= coll_reg | hit;
        r_cnt_reg <= r_cnt_reg + 2'd1;
      end else if (state_reg == ST_WRITE) begin
        r_cnt_reg <= r_cnt_reg + 2'd1;
      end
      if (state_next == ST_RESP) begin
        rsp_coll_reg <= coll_reg | ((state_reg == ST_CHECK) && hit);
      end
    end
  end

`ifdef LINE_CLEAR_EN
  // Clear scan pointer (bottom-up) and cleared-line counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg       <= '0;
      lines_reg     <= '0;
      rsp_lines_reg <= '0;
    end else begin
      if (accept) begin
        lines_reg <= '0;
      end else if (state_reg == ST_WRITE) begin
        ptr_reg <= ROW_AW'(ROWS - 1);
      end else if (state_reg == ST_CLEAR) begin
        if (row_full)             lines_reg <= lines_reg + 3'd1;
        else if (ptr_reg != '0)   ptr_reg   <= ptr_reg - ROW_AW'(1);
      end
      if (state_next == ST_RESP) begin
        rsp_lines_reg <= lines_reg;
      end
    end
  end
`endif

endmodule
